// File: rtl/register_file_2r1w_if.sv
// Register-file access bundle: two read ports, one write port, clear control.
// Master drives requests (decode/writeback side); slave is the register file.
interface register_file_2r1w_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    logic              rd_en_a;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [DATA_W-1:0] rd_data_a;
    logic              rd_valid_a;
    logic              rd_en_b;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_b;
    logic              rd_valid_b;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              clr_req;
    logic              clr_busy;
    logic              wr_drop;

    modport master (
        output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
        output wr_en, wr_addr, wr_data, clr_req,
        input  rd_data_a, rd_valid_a, rd_data_b, rd_valid_b,
        input  clr_busy, wr_drop
    );

    modport slave (
        input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
        input  wr_en, wr_addr, wr_data, clr_req,
        output rd_data_a, rd_valid_a, rd_data_b, rd_valid_b,
        output clr_busy, wr_drop
    );
endinterface

// File: rtl/register_file_2r1w.sv
// 2-read/1-write register file with sequenced bulk clear.
// Define REGFILE_BYPASS_EN for write-first forwarding on the read ports.
module register_file_2r1w #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input logic                 clk,
    input logic                 reset,
    register_file_2r1w_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] idx;
    logic              wr_ok;
    logic              clr_on;
    logic [DATA_W-1:0] rd_nx_a;
    logic [DATA_W-1:0] rd_nx_b;
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (bus.clr_req) state_nx = CLEAR;
            CLEAR: if (idx == LAST) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        clr_on       = (state == CLEAR);
        wr_ok        = bus.wr_en && (state == IDLE);
        bus.clr_busy = clr_on;
    end

    always_ff @(posedge clk) begin
        if (reset)       idx <= '0;
        else if (clr_on) idx <= idx + 1'b1;
        else             idx <= '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr_on) begin
            mem[idx] <= '0;
        end else if (wr_ok) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_comb begin
        rd_nx_a = mem[bus.rd_addr_a];
        rd_nx_b = mem[bus.rd_addr_b];
`ifdef REGFILE_BYPASS_EN
        // Dropped writes never forward; the entry under the sweep reads as zero.
        if (wr_ok && bus.wr_addr == bus.rd_addr_a)
            rd_nx_a = bus.wr_data;
        else if (clr_on && idx == bus.rd_addr_a)
            rd_nx_a = '0;
        if (wr_ok && bus.wr_addr == bus.rd_addr_b)
            rd_nx_b = bus.wr_data;
        else if (clr_on && idx == bus.rd_addr_b)
            rd_nx_b = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rd_data_a  <= '0;
            bus.rd_valid_a <= 1'b0;
            bus.rd_data_b  <= '0;
            bus.rd_valid_b <= 1'b0;
            bus.wr_drop    <= 1'b0;
        end else begin
            bus.rd_valid_a <= bus.rd_en_a;
            bus.rd_valid_b <= bus.rd_en_b;
            if (bus.rd_en_a) bus.rd_data_a <= rd_nx_a;
            if (bus.rd_en_b) bus.rd_data_b <= rd_nx_b;
            bus.wr_drop <= bus.wr_en && clr_on;
        end
    end
endmodule

// File: tb/tb_register_file_2r1w.sv
// Directed bench for register_file_2r1w (DATA_W=8, ADDR_W=2).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_register_file_2r1w;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;
    int   busy_cnt;

    register_file_2r1w_if #(.DATA_W(8), .ADDR_W(2)) bus ();

    register_file_2r1w #(.DATA_W(8), .ADDR_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [1:0] aa,
                      input logic [1:0] ab, input logic [7:0] ea,
                      input logic [7:0] eb);
        bus.rd_en_a   = 1'b1;
        bus.rd_addr_a = aa;
        bus.rd_en_b   = 1'b1;
        bus.rd_addr_b = ab;
        @(negedge clk);
        bus.rd_en_a = 1'b0;
        bus.rd_en_b = 1'b0;
        bus.wr_en   = 1'b0;
        check({tag, "_a"}, bus.rd_data_a, ea);
        check({tag, "_b"}, bus.rd_data_b, eb);
        check({tag, "_va"}, bus.rd_valid_a, 1);
        check({tag, "_vb"}, bus.rd_valid_b, 1);
    endtask

    task automatic fill();
        wr(2'd0, 8'h11);
        wr(2'd1, 8'h22);
        wr(2'd2, 8'h33);
        wr(2'd3, 8'h44);
    endtask

    // Pulse clr_req, drop a write on the first busy cycle, count busy cycles.
    task automatic sweep(input bit reassert, output int cnt);
        cnt = 0;
        bus.clr_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.clr_busy) cnt++;
            if (k == 0) begin
                bus.clr_req = 1'b0;
                bus.wr_en   = 1'b1;
                bus.wr_addr = 2'd0;
                bus.wr_data = 8'h99;
            end
            if (k == 1) begin
                check("drop_pulse", bus.wr_drop, 1);
                bus.wr_en   = 1'b0;
                bus.clr_req = reassert;
            end
            if (k == 2) begin
                check("drop_end", bus.wr_drop, 0);
                bus.clr_req = 1'b0;
            end
        end
    endtask

    initial begin
        bus.rd_en_a = 0; bus.rd_addr_a = 0;
        bus.rd_en_b = 0; bus.rd_addr_b = 0;
        bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
        bus.clr_req = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // 1: reset after writes
        wr(2'd0, 8'hde); wr(2'd1, 8'had); wr(2'd2, 8'hbe); wr(2'd3, 8'hef);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_va", bus.rd_valid_a, 0);
        check("rst_vb", bus.rd_valid_b, 0);
        check("rst_busy", bus.clr_busy, 0);
        check("rst_drop", bus.wr_drop, 0);
        for (int i = 0; i < 4; i++)
            rd("rst_rd", 2'(i), 2'(3 - i), 8'h00, 8'h00);
        @(negedge clk);
        check("va_fall", bus.rd_valid_a, 0);

        // 2: basic write then read on both ports
        wr(2'd1, 8'ha5);
        wr(2'd2, 8'h3c);
        rd("basic", 2'd1, 2'd2, 8'ha5, 8'h3c);
        rd("same", 2'd2, 2'd2, 8'h3c, 8'h3c);
        @(negedge clk);
        check("hold_a", bus.rd_data_a, 8'h3c);

        // 3: same-edge read/write collision
        wr(2'd3, 8'h11);
        bus.wr_en = 1'b1; bus.wr_addr = 2'd3; bus.wr_data = 8'h77;
`ifdef REGFILE_BYPASS_EN
        rd("rw_same", 2'd3, 2'd3, 8'h77, 8'h77);
`else
        rd("rw_same", 2'd3, 2'd3, 8'h11, 8'h11);
`endif
        rd("rw_after", 2'd3, 2'd1, 8'h77, 8'ha5);

        // 4: sweep with a dropped write
        fill();
        sweep(1'b0, busy_cnt);
        check("busy_cyc", busy_cnt, 4);
        check("busy_end", bus.clr_busy, 0);
        rd("clr01", 2'd0, 2'd1, 8'h00, 8'h00);
        rd("clr23", 2'd2, 2'd3, 8'h00, 8'h00);

        // 5: reset on the second busy cycle
        fill();
        bus.clr_req = 1'b1;
        @(negedge clk);
        bus.clr_req = 1'b0;
        check("mid_busy1", bus.clr_busy, 1);
        @(negedge clk);
        check("mid_busy2", bus.clr_busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_busy", bus.clr_busy, 0);
        rd("mid01", 2'd0, 2'd1, 8'h00, 8'h00);
        rd("mid23", 2'd2, 2'd3, 8'h00, 8'h00);
        wr(2'd3, 8'h5a);
        check("post_drop", bus.wr_drop, 0);
        rd("post_rd", 2'd3, 2'd0, 8'h5a, 8'h00);

        // 6: clr_req re-asserted mid-sweep does not extend it
        fill();
        sweep(1'b1, busy_cnt);
        check("re_busy_cyc", busy_cnt, 4);
        rd("re01", 2'd0, 2'd1, 8'h00, 8'h00);
        rd("re23", 2'd2, 2'd3, 8'h00, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
